chdr_deframer: RTL and testbench

CHDR_DEFRAMER -- requirements
Module: chdr_deframer

---
 rtl/chdr_pkg.sv | 23 ++
 rtl/chdr_hdr_decode.sv | 32 +++
 rtl/chdr_deframer.sv | 214 +++++++++++++++++++++
 tb/tb_chdr_deframer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chdr_pkg.sv
// chdr_pkg -- shared definitions for the CHDR deframer.
//   Header bit positions, header/time line sizes in bytes, and the
//   deframer state encoding. Imported by chdr_hdr_decode and chdr_deframer.
package chdr_pkg;

  // CHDR header field positions (64-bit header line)
  localparam int HDR_HAS_TIME_BIT = 61;
  localparam int HDR_LEN_MSB      = 47;
  localparam int HDR_LEN_LSB      = 32;

  // Byte sizes of the header and optional time line, both counted in length
  localparam logic [15:0] HDR_BYTES  = 16'd8;
  localparam logic [15:0] TIME_BYTES = 16'd8;

  typedef enum logic [2:0] {
    ST_HEAD = 3'd0,
    ST_TIME = 3'd1,
    ST_HI   = 3'd2,
    ST_LO   = 3'd3,
    ST_DROP = 3'd4
  } state_e;

endpackage

// File: rtl/chdr_hdr_decode.sv
// chdr_hdr_decode -- combinational CHDR header field extraction.
//   hdr_i        : raw 64-bit header line
//   hdr_o        : the same header, handed back for capture by the caller
//   has_time_o   : header carries a time line
//   n_samples_o  : number of 32-bit payload samples, 0 on underflow
//   misaligned_o : length is not a multiple of 4 bytes
module chdr_hdr_decode
  import chdr_pkg::*;
(
  input  logic [63:0] hdr_i,
  output logic [63:0] hdr_o,
  output logic        has_time_o,
  output logic [15:0] n_samples_o,
  output logic        misaligned_o
);

  logic [15:0] length;
  logic [15:0] overhead;
  logic [15:0] payload;

  always_comb begin
    hdr_o        = hdr_i;
    has_time_o   = hdr_i[HDR_HAS_TIME_BIT];
    length       = hdr_i[HDR_LEN_MSB:HDR_LEN_LSB];
    overhead     = has_time_o ? (HDR_BYTES + TIME_BYTES) : HDR_BYTES;
    payload      = length - overhead;
    // A length shorter than the header (and time) would wrap; call it empty.
    n_samples_o  = (length < overhead) ? 16'd0 : {2'b00, payload[15:2]};
    misaligned_o = |length[1:0];
  end

endmodule

// File: rtl/chdr_deframer.sv
// chdr_deframer -- splits 64-bit CHDR packet lines into 32-bit samples.
//   clk, reset_n (sync, active-low), clear (sync flush to HEAD)
//   i_tdata/i_tlast/i_tvalid/i_tready : CHDR line input (AXI-stream)
//   o_tdata/o_tlast/o_tvalid/o_tready : payload sample output (AXI-stream)
//   o_tuser : {header, time} of the current packet, stable for the packet
//   err     : one-cycle pulse per malformed packet
//   CHECK_LENGTH=1 cross-checks the header length against i_tlast;
//   CHECK_LENGTH=0 lets i_tlast alone delimit packets.
// The sample path is combinational: a line is consumed in the same cycle
// its last emitted half transfers.
module chdr_deframer
  import chdr_pkg::*;
#(
  parameter bit CHECK_LENGTH = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic [63:0]  i_tdata,
  input  logic         i_tlast,
  input  logic         i_tvalid,
  output logic         i_tready,
  output logic [31:0]  o_tdata,
  output logic [127:0] o_tuser,
  output logic         o_tlast,
  output logic         o_tvalid,
  input  logic         o_tready,
  output logic         err
);

  state_e      state_q, state_d;
  logic [63:0] hdr_q, hdr_d;
  logic [63:0] time_q, time_d;
  logic [15:0] n_q, n_d;        // samples in this packet
  logic [15:0] cnt_q, cnt_d;    // samples emitted so far
  logic        err_q, err_d;
  logic        err_done_q, err_done_d;

  logic [63:0] dec_hdr;
  logic        dec_has_time;
  logic [15:0] dec_n;
  logic        dec_misaligned;

  logic        last_sample;
  logic        out_fire;
  logic        hdr_acc;
  logic        bad_evt;
  logic        bad;

  chdr_hdr_decode u_decode (
    .hdr_i        (i_tdata),
    .hdr_o        (dec_hdr),
    .has_time_o   (dec_has_time),
    .n_samples_o  (dec_n),
    .misaligned_o (dec_misaligned)
  );

  // NOTE: every signal driven here gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    time_d   = time_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    hdr_acc  = 1'b0;
    bad_evt  = 1'b0;
    i_tready = 1'b0;
    o_tvalid = 1'b0;
    o_tlast  = 1'b0;
    o_tdata  = '0;

    last_sample = ((cnt_q + 16'd1) == n_q);
    out_fire    = i_tvalid && o_tready;

    unique case (state_q)
      ST_HEAD: begin
        i_tready = 1'b1;
        if (i_tvalid) begin
          hdr_acc = 1'b1;
          hdr_d   = dec_hdr;
          time_d  = '0;
          n_d     = dec_n;
          cnt_d   = '0;
          bad_evt = dec_misaligned;
          if (dec_has_time) begin
            if (i_tlast) begin
              bad_evt = 1'b1;
              state_d = ST_HEAD;
            end else begin
              state_d = ST_TIME;
            end
          end else if (CHECK_LENGTH && dec_n == 16'd0) begin
            // Empty packet: a header-only line ending here is complete.
            state_d = i_tlast ? ST_HEAD : ST_DROP;
          end else if (i_tlast) begin
            bad_evt = 1'b1;
            state_d = ST_HEAD;
          end else begin
            state_d = ST_HI;
          end
        end
      end

      ST_TIME: begin
        i_tready = 1'b1;
        if (i_tvalid) begin
          time_d = i_tdata;
          if (CHECK_LENGTH && n_q == 16'd0) begin
            state_d = i_tlast ? ST_HEAD : ST_DROP;
          end else if (i_tlast) begin
            bad_evt = 1'b1;
            state_d = ST_HEAD;
          end else begin
            state_d = ST_HI;
          end
        end
      end

      ST_HI: begin
        o_tdata  = i_tdata[63:32];
        o_tvalid = i_tvalid;
        if (CHECK_LENGTH && last_sample) begin
          // Odd sample count: the lower half of this line is discarded.
          o_tlast  = 1'b1;
          i_tready = o_tready;
          if (out_fire) begin
            cnt_d = cnt_q + 16'd1;
            if (i_tlast) begin
              state_d = ST_HEAD;
            end else begin
              bad_evt = 1'b1;
              state_d = ST_DROP;
            end
          end
        end else if (out_fire) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = ST_LO;
        end
      end

      ST_LO: begin
        o_tdata  = i_tdata[31:0];
        o_tvalid = i_tvalid;
        i_tready = o_tready;
        if (CHECK_LENGTH) begin
          o_tlast = last_sample || i_tlast;
          if (out_fire) begin
            cnt_d = cnt_q + 16'd1;
            if (last_sample) begin
              bad_evt = !i_tlast;
              state_d = i_tlast ? ST_HEAD : ST_DROP;
            end else if (i_tlast) begin
              bad_evt = 1'b1;
              state_d = ST_HEAD;
            end else begin
              state_d = ST_HI;
            end
          end
        end else begin
          o_tlast = i_tlast;
          if (out_fire) begin
            cnt_d   = cnt_q + 16'd1;
            state_d = i_tlast ? ST_HEAD : ST_HI;
          end
        end
      end

      ST_DROP: begin
        i_tready = 1'b1;
        if (i_tvalid && i_tlast) begin
          state_d = ST_HEAD;
        end
      end

      default: begin
        state_d = ST_HEAD;
      end
    endcase

    // Only one err pulse per packet; a new header re-arms it.
    bad        = bad_evt && CHECK_LENGTH;
    err_d      = bad && (hdr_acc || !err_done_q);
    err_done_d = hdr_acc ? bad : (err_done_q || bad);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge next-state value.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      // NOTE: the header and time registers are reset as well because they
      // drive o_tuser, which must read zero after reset.
      state_q    <= ST_HEAD;
      hdr_q      <= '0;
      time_q     <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      time_q     <= time_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_done_q <= err_done_d;
    end
  end

  assign o_tuser = {hdr_q, time_q};
  assign err     = err_q;

endmodule

// File: tb/tb_chdr_deframer.sv
// tb_chdr_deframer -- self-checking bench for chdr_deframer (CHECK_LENGTH=1).
//   Each packet task derives the expected sample stream from the header and
//   the payload it drives, queues it, and the per-cycle tick() pops and
//   compares every output transfer.
module tb_chdr_deframer;

  typedef struct packed {
    logic [31:0]  data;
    logic         last;
    logic [127:0] user;
  } beat_t;

  localparam logic [63:0] H035 = 64'h3123_0060_89ab_cdef;
  localparam logic [63:0] T035 = 64'h0011_2233_4455_0000;

  logic         clk;
  logic         reset_n;
  logic         clear;
  logic [63:0]  i_tdata;
  logic         i_tlast;
  logic         i_tvalid;
  logic         i_tready;
  logic [31:0]  o_tdata;
  logic [127:0] o_tuser;
  logic         o_tlast;
  logic         o_tvalid;
  logic         o_tready;
  logic         err;

  beat_t       sb[$];
  logic [63:0] pay [1:64];
  int          checks   = 0;
  int          failures = 0;
  int          err_cnt  = 0;
  int          cyc      = 0;
  bit          acc      = 1'b0;
  bit          stall_en = 1'b0;
  bit          gaps_en  = 1'b0;

  chdr_deframer #(.CHECK_LENGTH(1'b1)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tuser  (o_tuser),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: observe at the falling edge, advance past the rising edge.
  task automatic tick();
    beat_t e;
    @(negedge clk);
    acc = i_tvalid && i_tready;
    if (o_tvalid === 1'b1 && o_tready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL beat: unexpected output data=%h last=%b", o_tdata, o_tlast);
      end else begin
        e = sb.pop_front();
        if ({o_tdata, o_tlast, o_tuser} !== {e.data, e.last, e.user}) begin
          failures++;
          $display("FAIL beat: got data=%h last=%b user=%h, want data=%h last=%b user=%h",
                   o_tdata, o_tlast, o_tuser, e.data, e.last, e.user);
        end
      end
    end
    if (err === 1'b1) err_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    o_tready = stall_en ? ((cyc % 320) < 200) : 1'b1;
  endtask

  task automatic send_line(input logic [63:0] d, input bit last);
    if (gaps_en) begin
      repeat ($urandom_range(0, 3)) begin
        i_tvalid = 1'b0;
        tick();
      end
    end
    i_tdata  = d;
    i_tlast  = last;
    i_tvalid = 1'b1;
    for (int t = 0; ; t++) begin
      tick();
      if (acc) break;
      if (t >= 2000) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: line %h not accepted within 2000 cycles", d);
        break;
      end
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic fill_payload(input int npay, input bit rand_data);
    logic [31:0] base;
    base = 32'hA000_0000;
    for (int k = 1; k <= npay; k++) begin
      if (rand_data) pay[k] = {$urandom(), $urandom()};
      else           pay[k] = {base + 32'(2 * k - 1), base + 32'(2 * k)};
    end
  endtask

  // Drives one packet; tlast goes on the last payload line, or on the
  // header/time line when npay is 0.
  task automatic send_packet(input logic [63:0] hdr, input logic [63:0] tm,
                             input int npay, input bit rand_data, input string name);
    logic        has_t;
    logic [15:0] len, ovh, n;
    logic [63:0] line;
    int          exp_err;
    beat_t       b;
    has_t = hdr[61];
    len   = hdr[47:32];
    ovh   = has_t ? 16'd16 : 16'd8;
    n     = (len < ovh) ? 16'd0 : ((len - ovh) >> 2);
    fill_payload(npay, rand_data);
    for (int k = 1; k <= npay; k++) begin
      line = pay[k];
      for (int h = 0; h < 2; h++) begin
        if (2 * k - 1 + h <= int'(n)) begin
          b.data = (h == 0) ? line[63:32] : line[31:0];
          b.last = (2 * k - 1 + h == int'(n)) || (k == npay && h == 1);
          b.user = {hdr, has_t ? tm : 64'h0};
          sb.push_back(b);
        end
      end
    end
    exp_err = ((len[1:0] != 2'b00) || (n != 16'd0 && int'((n + 16'd1) / 16'd2) != npay)) ? 1 : 0;
    err_cnt = 0;
    send_line(hdr, !has_t && npay == 0);
    if (has_t) send_line(tm, npay == 0);
    for (int k = 1; k <= npay; k++) send_line(pay[k], k == npay);
    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d samples missing, want 0", name, sb.size());
      sb.delete();
    end
    checks++;
    if (err_cnt != exp_err) begin
      failures++;
      $display("FAIL %s_err: err pulses=%0d, want %0d", name, err_cnt, exp_err);
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    clear    = 1'b0;
    i_tdata  = '0;
    i_tlast  = 1'b0;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({i_tready, o_tvalid, o_tlast, err} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_ctrl: i_tready,o_tvalid,o_tlast,err=%b, want 1000",
               {i_tready, o_tvalid, o_tlast, err});
    end
    checks++;
    if (o_tuser !== 128'h0) begin
      failures++;
      $display("FAIL reset_tuser: got %h, want 0", o_tuser);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_time();
    send_packet(H035, T035, 10, 1'b0, "basic_time");
  endtask

  task automatic test_odd_no_time();
    send_packet(64'h0000_001C_0000_1234, 64'h0, 3, 1'b1, "odd_no_time");
  endtask

  task automatic test_stall();
    stall_en = 1'b1;
    gaps_en  = 1'b1;
    cyc      = 0;
    for (int p = 0; p < 8; p++) send_packet(H035, T035, 10, 1'b0, "stall");
    stall_en = 1'b0;
    gaps_en  = 1'b0;
    o_tready = 1'b1;
  endtask

  task automatic test_early_tlast();
    send_packet(H035, T035, 6, 1'b1, "early_tlast");
    send_packet(64'h0000_001C_0000_5678, 64'h0, 3, 1'b1, "after_early");
  endtask

  task automatic test_late_tlast();
    send_packet(64'h2000_0030_0000_0042, 64'h0000_0000_0000_9999, 8, 1'b1, "late_tlast");
  endtask

  task automatic test_misaligned();
    send_packet(64'h0000_001E_0000_0007, 64'h0, 3, 1'b1, "misaligned");
  endtask

  task automatic test_empty();
    send_packet(64'h0000_0008_0000_0001, 64'h0, 0, 1'b1, "empty_hdr_only");
    send_packet(64'h2000_0010_0000_0002, 64'h0000_0000_0000_1111, 2, 1'b1, "empty_drop");
  endtask

  task automatic test_truncated();
    send_packet(H035, T035, 0, 1'b1, "truncated");
  endtask

  // Abandons a 035 packet while sample 7 is presented, via reset or clear.
  task automatic test_abort(input bit use_clear, input string name);
    beat_t b;
    fill_payload(10, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      b.last = 1'b0;
      b.user = {H035, T035};
      b.data = pay[k][63:32];
      sb.push_back(b);
      b.data = pay[k][31:0];
      sb.push_back(b);
    end
    err_cnt = 0;
    send_line(H035, 1'b0);
    send_line(T035, 1'b0);
    for (int k = 1; k <= 3; k++) send_line(pay[k], 1'b0);
    i_tdata  = pay[4];
    i_tlast  = 1'b0;
    i_tvalid = 1'b1;
    o_tready = 1'b0;
    if (use_clear) clear = 1'b1;
    else           reset_n = 1'b0;
    tick();
    clear    = 1'b0;
    reset_n  = 1'b1;
    i_tvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_tvalid, o_tlast, err, i_tready} !== 4'b0001 || o_tuser !== 128'h0) begin
      failures++;
      $display("FAIL %s_outputs: o_tvalid,o_tlast,err,i_tready=%b user=%h, want 0001 and 0",
               name, {o_tvalid, o_tlast, err, i_tready}, o_tuser);
    end
    checks++;
    if (sb.size() != 0 || err_cnt != 0) begin
      failures++;
      $display("FAIL %s_partial: %0d samples missing, err pulses=%0d, want 0 and 0",
               name, sb.size(), err_cnt);
      sb.delete();
    end
    @(posedge clk);
    #1;
    send_packet(H035, T035, 10, 1'b0, {name, "_next"});
  endtask

  initial begin
    test_reset();
    test_basic_time();
    test_odd_no_time();
    test_stall();
    test_early_tlast();
    test_late_tlast();
    test_misaligned();
    test_empty();
    test_truncated();
    test_abort(1'b0, "reset_mid");
    test_abort(1'b1, "clear_mid");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
